sram_ana_master: RTL and testbench

Synthesizable initiator for the analog-level SRAM interface. Accepts digital read/write requests over a valid/ready handshake and encodes each address and data bit as a 0 or FULL_SCALE level. Generates the SRAM's level-coded clock pulse and write enable, then decodes `dout_a` back to bits with a threshold comparator and returns a response. It sits between digital control logic and the `sram` macro, and replaces bench-side drive tasks in integrated designs.

---
 rtl/sram_ana_master.sv | 122 ++++++++++++
 tb/tb_sram_ana_master.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/sram_ana_master.sv
// Digital request/response initiator for the level-coded SRAM macro.
// Encodes address/data as 0/FULL_SCALE levels, pulses clk_a once, threshold-decodes dout_a.
module sram_ana_lane #(
  parameter int ANA_WIDTH = 8,
  parameter int THRESH    = 127,
  parameter int MARGIN    = 16
) (
  input  logic [ANA_WIDTH-1:0] level,
  output logic                 hi,
  output logic                 marg
);
  // One extra bit of headroom keeps THRESH+-MARGIN from wrapping.
  localparam int BAND_LO = THRESH - MARGIN;
  localparam int BAND_HI = THRESH + MARGIN;
  localparam logic [ANA_WIDTH:0] TH_W = THRESH[ANA_WIDTH:0];
  localparam logic [ANA_WIDTH:0] LO_W = (BAND_LO < 0) ? '0 : BAND_LO[ANA_WIDTH:0];
  localparam logic [ANA_WIDTH:0] HI_W = BAND_HI[ANA_WIDTH:0];

  logic [ANA_WIDTH:0] lvl;
  assign lvl  = {1'b0, level};
  assign hi   = lvl > TH_W;
  assign marg = ((BAND_LO < 0) || (lvl > LO_W)) && (lvl <= HI_W);
endmodule

module sram_ana_master #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int ANA_WIDTH  = 8,
  parameter int FULL_SCALE = 255,
  parameter int THRESH     = FULL_SCALE / 2,
  parameter int MARGIN     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_we,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_marginal,
  output logic [ANA_WIDTH-1:0]  clk_a,
  output logic [ANA_WIDTH-1:0]  we_a,
  output logic [ANA_WIDTH-1:0]  addr_a [ADDR_WIDTH],
  output logic [ANA_WIDTH-1:0]  din_a  [DATA_WIDTH],
  input  logic [ANA_WIDTH-1:0]  dout_a [DATA_WIDTH]
);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETUP  = 3'd1;
  localparam logic [2:0] S_EDGE   = 3'd2;
  localparam logic [2:0] S_SAMPLE = 3'd3;
  localparam logic [2:0] S_RESP   = 3'd4;

  localparam logic [ANA_WIDTH-1:0] LVL_HI = FULL_SCALE[ANA_WIDTH-1:0];
  localparam logic [ANA_WIDTH-1:0] LVL_LO = '0;

  logic [2:0]            state;
  logic                  we_q;
  logic [DATA_WIDTH-1:0] dec_bits;
  logic [DATA_WIDTH-1:0] dec_marg;

  for (genvar g = 0; g < DATA_WIDTH; g++) begin : g_lane
    sram_ana_lane #(.ANA_WIDTH(ANA_WIDTH), .THRESH(THRESH), .MARGIN(MARGIN)) u_lane (
      .level (dout_a[g]),
      .hi    (dec_bits[g]),
      .marg  (dec_marg[g])
    );
  end

  // Outputs are loaded one state early so every level is registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      we_q         <= 1'b0;
      req_ready    <= 1'b1;
      rsp_valid    <= 1'b0;
      rsp_we       <= 1'b0;
      rsp_rdata    <= '0;
      rsp_marginal <= 1'b0;
      clk_a        <= LVL_LO;
      we_a         <= LVL_LO;
      for (int i = 0; i < ADDR_WIDTH; i++) addr_a[i] <= LVL_LO;
      for (int i = 0; i < DATA_WIDTH; i++) din_a[i]  <= LVL_LO;
    end else begin
      case (state)
        S_IDLE: if (req_valid) begin
          state     <= S_SETUP;
          req_ready <= 1'b0;
          we_q      <= req_we;
          we_a      <= req_we ? LVL_HI : LVL_LO;
          for (int i = 0; i < ADDR_WIDTH; i++) addr_a[i] <= req_addr[i]  ? LVL_HI : LVL_LO;
          for (int i = 0; i < DATA_WIDTH; i++) din_a[i]  <= req_wdata[i] ? LVL_HI : LVL_LO;
        end
        S_SETUP: begin
          state <= S_EDGE;
          clk_a <= LVL_HI;
        end
        S_EDGE: begin
          state <= S_SAMPLE;
          clk_a <= LVL_LO;
          we_a  <= LVL_LO;
        end
        S_SAMPLE: begin
          state        <= S_RESP;
          rsp_valid    <= 1'b1;
          rsp_we       <= we_q;
          rsp_rdata    <= we_q ? '0 : dec_bits;
          rsp_marginal <= !we_q && (|dec_marg);
        end
        S_RESP: if (rsp_ready) begin
          state     <= S_IDLE;
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sram_ana_master.sv
// Bench for sram_ana_master: behavioural SRAM, timeline model of the expected outputs,
// per-cycle compare plus directed literal checks.
module tb_sram_ana_master;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b1;
  logic [3:0] req_addr = '0;
  logic [7:0] req_wdata = '0;
  logic       req_ready, rsp_valid, rsp_we, rsp_marginal;
  logic [7:0] rsp_rdata, clk_a, we_a;
  logic [7:0] addr_a [4];
  logic [7:0] din_a  [8];
  logic [7:0] dout_a [8];

  int checks = 0, errors = 0, cyc = 0;

  sram_ana_master dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_we(rsp_we), .rsp_rdata(rsp_rdata), .rsp_marginal(rsp_marginal), .clk_a(clk_a),
    .we_a(we_a), .addr_a(addr_a), .din_a(din_a), .dout_a(dout_a)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Behavioural SRAM macro: acts on each rising crossing of clk_a.
  logic [7:0] mem [16];
  logic [7:0] sram_q = '0;
  bit         clk_prev = 1'b0;
  bit         force_en = 1'b0;
  logic [7:0] force_lvl [8];
  initial for (int i = 0; i < 16; i++) mem[i] = '0;

  always @(posedge clk) begin : sram_mdl
    logic [3:0] a;
    logic [7:0] d;
    clk_prev <= (clk_a > 8'd127);
    if (clk_a > 8'd127 && !clk_prev) begin
      for (int i = 0; i < 4; i++) a[i] = addr_a[i] > 8'd127;
      for (int i = 0; i < 8; i++) d[i] = din_a[i] > 8'd127;
      if (we_a > 8'd127) mem[a] <= d;
      else               sram_q <= mem[a];
    end
  end

  always_comb begin
    for (int i = 0; i < 8; i++) dout_a[i] = force_en ? force_lvl[i] : (sram_q[i] ? 8'd255 : 8'd0);
  end

  // Expected-output model: each transaction is a timeline counted from acceptance.
  bit         m_ok = 1'b0, m_busy = 1'b0, m_we = 1'b0;
  int         m_age = 0;
  logic [3:0] m_addr = '0;
  logic [7:0] m_din = '0;
  logic       m_rsp_we = 1'b0, m_marg = 1'b0;
  logic [7:0] m_rdata = '0;

  always @(posedge clk) begin : model
    logic [7:0] b;
    logic       mg;
    int         lv;
    b = '0; mg = 1'b0;
    for (int i = 0; i < 8; i++) begin
      lv = int'(dout_a[i]);
      b[i] = lv > 127;
      if (lv > 127 - 16 && lv <= 127 + 16) mg = 1'b1;
    end
    if (rst) begin
      m_ok <= 1'b1; m_busy <= 1'b0; m_age <= 0; m_we <= 1'b0;
      m_addr <= '0; m_din <= '0; m_rsp_we <= 1'b0; m_rdata <= '0; m_marg <= 1'b0;
    end else if (!m_busy) begin
      if (req_valid) begin
        m_busy <= 1'b1; m_age <= 1; m_we <= req_we; m_addr <= req_addr; m_din <= req_wdata;
      end
    end else begin
      m_age <= m_age + 1;
      if (m_age == 3) begin
        m_rsp_we <= m_we;
        m_rdata  <= m_we ? 8'h00 : b;
        m_marg   <= !m_we && mg;
      end
      if (m_age >= 4 && rsp_ready) m_busy <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      chk("req_ready", req_ready, !m_busy);
      chk("rsp_valid", rsp_valid, m_busy && m_age >= 4);
      chk("clk_a", clk_a, (m_busy && m_age == 2) ? 255 : 0);
      chk("we_a", we_a, (m_busy && m_we && (m_age == 1 || m_age == 2)) ? 255 : 0);
      for (int i = 0; i < 4; i++) chk($sformatf("addr_a[%0d]", i), addr_a[i], m_addr[i] ? 255 : 0);
      for (int i = 0; i < 8; i++) chk($sformatf("din_a[%0d]", i), din_a[i], m_din[i] ? 255 : 0);
      chk("rsp_we", rsp_we, m_rsp_we);
      chk("rsp_rdata", rsp_rdata, m_rdata);
      chk("rsp_marginal", rsp_marginal, m_marg);
    end
  end

  // Present a request; returns the acceptance cycle.
  task automatic issue(input logic we, input logic [3:0] a, input logic [7:0] d, output int t);
    bit ok;
    ok = 1'b0; t = -1;
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      if (req_ready === 1'b1) ok = 1'b1;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL issue_timeout act=no_accept exp=accept addr=%0h", a);
    end else t = cyc;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output logic [7:0] rd, output logic mg, output int at);
    bit ok;
    ok = 1'b0; rd = 'x; mg = 1'bx; at = -1;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin ok = 1'b1; rd = rsp_rdata; mg = rsp_marginal; at = cyc; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL rsp_timeout act=no_rsp exp=rsp");
    end
  endtask

  initial begin
    int t, t2, at;
    logic [7:0] rd;
    logic mg;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_clk_a", clk_a, 0);
    chk("rst_we_a", we_a, 0);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    for (int i = 0; i < 4; i++) chk("rst_addr_a", addr_a[i], 0);
    for (int i = 0; i < 8; i++) chk("rst_din_a", din_a[i], 0);
    @(posedge clk); #1 rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      issue(1'b1, 4'(i), 8'(i), t);
      wait_rsp(rd, mg, at);
      chk("wr_latency", at - t, 4);
    end
    for (int i = 0; i < 16; i++) begin
      issue(1'b0, 4'(i), 8'h00, t);
      wait_rsp(rd, mg, at);
      chk("rd_data", rd, i);
      chk("rd_marginal", mg, 0);
    end

    force_lvl[0] = 8'd127; force_lvl[1] = 8'd128; force_lvl[2] = 8'd112;
    force_lvl[3] = 8'd111; force_lvl[4] = 8'd200;
    for (int i = 5; i < 8; i++) force_lvl[i] = 8'd0;
    force_en = 1'b1;
    issue(1'b0, 4'd9, 8'h00, t);
    wait_rsp(rd, mg, at);
    chk("thresh_bits", rd, 8'h12);
    chk("thresh_marginal", mg, 1);
    force_en = 1'b0;

    issue(1'b1, 4'd5, 8'hA5, t);
    wait_rsp(rd, mg, at);
    issue(1'b0, 4'd5, 8'h00, t);
    rsp_ready = 1'b0;
    wait_rsp(rd, mg, at);
    chk("bp_first", rd, 8'hA5);
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd0;
    repeat (10) begin
      @(negedge clk);
      chk("bp_valid", rsp_valid, 1);
      chk("bp_rdata", rsp_rdata, 8'hA5);
      chk("bp_req_ready", req_ready, 0);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_release_ready", req_ready, 1);
    @(posedge clk); #1 req_valid = 1'b0;
    wait_rsp(rd, mg, at);
    chk("bp_next_rd", rd, 8'h00);

    issue(1'b0, 4'd7, 8'h00, t);
    wait_rsp(rd, mg, at);
    chk("lat_rsp", at - t, 4);
    chk("lat_rd", rd, 8'h07);
    @(negedge clk);
    chk("lat_ready", req_ready, 1);
    chk("lat_ready_cyc", cyc - t, 5);
    issue(1'b0, 4'd15, 8'h00, t);
    wait_rsp(rd, mg, at);
    chk("wrap_addr_rd", rd, 8'h0F);
    issue(1'b0, 4'd2, 8'h00, t2);
    chk("b2b_spacing", t2 - t, 5);
    wait_rsp(rd, mg, at);

    issue(1'b1, 4'd3, 8'hFF, t);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_clk_a", clk_a, 0);
    chk("mid_rst_we_a", we_a, 0);
    chk("mid_rst_req_ready", req_ready, 1);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    for (int i = 0; i < 4; i++) chk("mid_rst_addr_a", addr_a[i], 0);
    for (int i = 0; i < 8; i++) chk("mid_rst_din_a", din_a[i], 0);
    repeat (8) begin
      @(negedge clk);
      chk("mid_rst_no_rsp", rsp_valid, 0);
    end
    issue(1'b0, 4'd3, 8'h00, t);
    wait_rsp(rd, mg, at);
    chk("post_rst_latency", at - t, 4);
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
